xor_pipe_unit: RTL

XOR_PIPE_UNIT -- requirements
Module: xor_pipe_unit

---
 rtl/xor_pipe_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/xor_pipe_unit.sv
// xor_pipe_unit: elastic DEPTH-stage pipeline computing bitwise ops on a, b.
// Coverage bins compiled in only with macro XOR_PIPE_COV_BINS_EN.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, a, b, op  : operand handshake (op 00 xor,
//                                  01 xnor, 10 and, 11 or)
//   out_valid/out_ready, y       : result handshake
//   count                        : saturating delivered-result counter
//   cov_clr, cov_bins, cov_full  : bin-hit bitmap on a's top bits
`timescale 1ns/1ps

module xor_pipe_unit #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int NBINS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [15:0]      count,
  input  logic             cov_clr,
  output logic [NBINS-1:0] cov_bins,
  output logic             cov_full
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [WIDTH-1:0] res;
  logic [15:0]      count_q, count_d;
  logic             deliver;

  always_comb begin
    res = '0;
    unique case (op)
      2'b00:   res = a ^ b;
      2'b01:   res = ~(a ^ b);
      2'b10:   res = a & b;
      2'b11:   res = a | b;
      default: res = '0;
    endcase
  end

  // Ready ripples from the output back to stage 0 so a full
  // pipeline can accept and deliver in the same cycle.
  always_comb begin
    logic go;
    go   = out_ready;
    load = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      load[i] = ~vld_q[i] | go;
      go      = load[i];
    end
  end

  assign in_ready  = reset & load[0];
  assign out_valid = vld_q[DEPTH-1];
  assign y         = dat_q[DEPTH-1];
  assign deliver   = vld_q[DEPTH-1] & out_ready;
  assign count     = count_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) dat_d[0] = res;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (load[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (deliver && count_q != 16'hFFFF)
      count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        dat_q[i] <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++)
        dat_q[i] <= dat_d[i];
    end
  end

`ifdef XOR_PIPE_COV_BINS_EN
  localparam int LB = $clog2(NBINS);
  localparam int CW = (LB > 0) ? LB : 1;
  localparam int SH = WIDTH - LB;

  logic [NBINS-1:0] bins_q, bins_d, hit;
  logic [CW-1:0]    idx;
  logic             full_q, full_d;

  assign idx = CW'(a >> SH);

  // A hit in the clearing cycle survives the clear.
  always_comb begin
    hit = '0;
    if (in_valid && in_ready) hit[idx] = 1'b1;
    bins_d = (cov_clr ? '0 : bins_q) | hit;
    full_d = &bins_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bins_q <= '0;
      full_q <= 1'b0;
    end else begin
      bins_q <= bins_d;
      full_q <= full_d;
    end
  end

  assign cov_bins = bins_q;
  assign cov_full = full_q;
`else
  logic unused_cov_clr;
  assign unused_cov_clr = cov_clr;
  assign cov_bins       = '0;
  assign cov_full       = 1'b0;
`endif

endmodule
